// File: rtl/fc2_layer_controller_if.sv
// Control bundle between the FC2 sequencer and the MAC / memory / output-FIFO datapath.
// The master modport is the sequencer side; the slave modport is the datapath or bench side.
interface fc2_layer_controller_if #(
    parameter int IFM_DEPTH       = 84,
    parameter int NUMBER_OF_WM    = 10,
    parameter int ADDRESS_BITS    = 15,
    parameter int ADDRESS_SIZE_WM = $clog2(IFM_DEPTH),
    parameter int NEURON_BITS     = $clog2(NUMBER_OF_WM)
);
    logic                       start;
    logic [ADDRESS_SIZE_WM-1:0] ifm_addr;
    logic [ADDRESS_BITS-1:0]    wm_addr;
    logic [NEURON_BITS-1:0]     neuron_idx;
    logic                       mac_enable;
    logic                       mac_clear;
    logic                       fifo_enable;
    logic                       busy;
    logic                       done;

    modport master (
        input  start,
        output ifm_addr, wm_addr, neuron_idx, mac_enable, mac_clear, fifo_enable, busy, done
    );

    modport slave (
        output start,
        input  ifm_addr, wm_addr, neuron_idx, mac_enable, mac_clear, fifo_enable, busy, done
    );
endinterface

// File: rtl/fc2_layer_controller.sv
// FC2 sequencer: 84 inputs x 10 neurons on one shared MAC; all outputs registered, one cycle behind the state.
// No backpressure: once started it runs a fixed schedule of 87 cycles per neuron, start is ignored until IDLE.
module fc2_layer_controller #(
    parameter int IFM_DEPTH       = 84,
    parameter int NUMBER_OF_WM    = 10,
    parameter int ADDRESS_BITS    = 15,
    parameter int ADDRESS_SIZE_WM = $clog2(IFM_DEPTH),
    parameter int NEURON_BITS     = $clog2(NUMBER_OF_WM),
    parameter int READ_LATENCY    = 1,
    parameter int MAC_LATENCY     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    fc2_layer_controller_if.master ctl
);

    localparam int DRAIN_CYCLES = READ_LATENCY + MAC_LATENCY;
    localparam int DRAIN_BITS   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [ADDRESS_SIZE_WM-1:0] I_LAST  = ADDRESS_SIZE_WM'(IFM_DEPTH - 1);
    localparam logic [ADDRESS_SIZE_WM-1:0] I_ONE   = ADDRESS_SIZE_WM'(1);
    localparam logic [NEURON_BITS-1:0]     N_LAST  = NEURON_BITS'(NUMBER_OF_WM - 1);
    localparam logic [NEURON_BITS-1:0]     N_ONE   = NEURON_BITS'(1);
    localparam logic [DRAIN_BITS-1:0]      D_LAST  = DRAIN_BITS'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_BITS-1:0]      D_ONE   = DRAIN_BITS'(1);
    localparam logic [ADDRESS_BITS-1:0]    WM_ONE  = ADDRESS_BITS'(1);

    // The flat weight address must reach NUMBER_OF_WM*IFM_DEPTH-1 without wrapping.
    generate
        if ((NUMBER_OF_WM * IFM_DEPTH - 1) >= (2 ** ADDRESS_BITS)) begin : g_wm_addr_too_narrow
            $error("ADDRESS_BITS too small for NUMBER_OF_WM*IFM_DEPTH weights");
        end
        if (READ_LATENCY < 1) begin : g_read_latency_invalid
            $error("READ_LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        DRAIN,
        PUSH,
        DONE
    } state_t;

    state_t                      state, state_n;
    logic [ADDRESS_SIZE_WM-1:0]  i_q, i_n;
    logic [NEURON_BITS-1:0]      neuron_q, neuron_n;
    logic [DRAIN_BITS-1:0]       drain_q, drain_n;
    logic [ADDRESS_BITS-1:0]     wm_q, wm_n;
    logic                        addr_valid_q;
    logic [READ_LATENCY-1:0]     vld_sr;

    always_comb begin
        state_n  = state;
        i_n      = i_q;
        neuron_n = neuron_q;
        drain_n  = drain_q;
        wm_n     = wm_q;
        case (state)
            IDLE: begin
                if (ctl.start) begin
                    state_n  = ACC;
                    i_n      = '0;
                    neuron_n = '0;
                    wm_n     = '0;
                end
            end
            ACC: begin
                // Weight address runs contiguously across neurons, so a plain incrementer suffices.
                wm_n = wm_q + WM_ONE;
                if (i_q == I_LAST) begin
                    state_n = DRAIN;
                    drain_n = '0;
                end else begin
                    i_n = i_q + I_ONE;
                end
            end
            DRAIN: begin
                if (drain_q == D_LAST) begin
                    state_n = PUSH;
                end else begin
                    drain_n = drain_q + D_ONE;
                end
            end
            PUSH: begin
                if (neuron_q == N_LAST) begin
                    state_n = DONE;
                end else begin
                    state_n  = ACC;
                    neuron_n = neuron_q + N_ONE;
                    i_n      = '0;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            i_q             <= '0;
            neuron_q        <= '0;
            drain_q         <= '0;
            wm_q            <= '0;
            addr_valid_q    <= 1'b0;
            vld_sr          <= '0;
            ctl.ifm_addr    <= '0;
            ctl.wm_addr     <= '0;
            ctl.neuron_idx  <= '0;
            ctl.mac_clear   <= 1'b0;
            ctl.fifo_enable <= 1'b0;
            ctl.busy        <= 1'b0;
            ctl.done        <= 1'b0;
        end else begin
            state    <= state_n;
            i_q      <= i_n;
            neuron_q <= neuron_n;
            drain_q  <= drain_n;
            wm_q     <= wm_n;

            addr_valid_q <= (state == ACC);
            vld_sr[0]    <= addr_valid_q;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_sr[k] <= vld_sr[k-1];
            end

            ctl.ifm_addr    <= i_q;
            ctl.wm_addr     <= wm_q;
            ctl.neuron_idx  <= neuron_q;
            // Push and clear share a cycle: the FIFO samples the accumulator on the same edge it zeroes.
            ctl.fifo_enable <= (state == PUSH);
            ctl.mac_clear   <= (state == PUSH);
            ctl.busy        <= (state != IDLE);
            ctl.done        <= (state == DONE);
        end
    end

    assign ctl.mac_enable = vld_sr[READ_LATENCY-1];

endmodule

// File: tb/tb_fc2_layer_controller.sv
// Directed bench for fc2_layer_controller with memory, MAC and output-FIFO models and a push scoreboard.
module tb_fc2_layer_controller;
    localparam int IFM_DEPTH = 84;
    localparam int NWM       = 10;
    localparam int P         = 87;
    localparam int SUM1      = 3570;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fc2_layer_controller_if bus ();

    fc2_layer_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int base     = 0;
    bit mon_on   = 1'b0;
    bit weighted = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath models: IFM[k] = k+1; weight = 1, or neuron+1 when weighted.
    int     ifm_dat = 0;
    int     w_dat   = 0;
    longint acc     = 0;
    longint fifo [NWM];

    always @(posedge clk) begin
        ifm_dat <= int'(bus.ifm_addr) + 1;
        w_dat   <= weighted ? (int'(bus.wm_addr) / IFM_DEPTH + 1) : 1;
        if (!reset)               acc <= 0;
        else if (bus.mac_clear)   acc <= 0;
        else if (bus.mac_enable)  acc <= acc + longint'(ifm_dat) * longint'(w_dat);
        if (bus.fifo_enable) begin
            for (int k = 0; k < NWM - 1; k++) fifo[k] <= fifo[k+1];
            fifo[NWM-1] <= acc;
        end
    end

    typedef struct {
        int     cyc;
        longint val;
    } exp_t;

    exp_t exp_q[$];

    int mac_cnt, fifo_cnt, done_cnt, done_cyc, addr_err, overlap_err, exp_wm;
    int prev_wm, prev_ifm;

    task automatic chk(input string tag, input longint got, input longint want);
        n_checks++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            int   rel;
            exp_t e;
            rel = cyc - base;
            if (bus.mac_enable) begin
                mac_cnt++;
                if (prev_wm != exp_wm) addr_err++;
                if (prev_ifm != exp_wm % IFM_DEPTH) addr_err++;
                exp_wm++;
                if (bus.fifo_enable || bus.done || bus.mac_clear) overlap_err++;
            end
            if (bus.fifo_enable) begin
                fifo_cnt++;
                chk("push_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("push_cycle", rel, e.cyc);
                    chk("push_value", acc, e.val);
                    chk("push_clear_together", bus.mac_clear, 1);
                    chk("mac_per_neuron", mac_cnt, IFM_DEPTH * fifo_cnt);
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = rel;
                chk("busy_with_done", bus.busy, 1);
            end
            prev_wm  = int'(bus.wm_addr);
            prev_ifm = int'(bus.ifm_addr);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_run();
        mac_cnt = 0; fifo_cnt = 0; done_cnt = 0; done_cyc = -1;
        addr_err = 0; overlap_err = 0; exp_wm = 0;
        exp_q.delete();
    endtask

    task automatic start_run(input bit w, input bit hold);
        exp_t e;
        clear_run();
        weighted = w;
        for (int n = 0; n < NWM; n++) begin
            e.cyc = (n + 1) * P;
            e.val = w ? longint'(SUM1 * (n + 1)) : longint'(SUM1);
            exp_q.push_back(e);
        end
        bus.start = 1'b1;
        step(1);
        base   = cyc;
        mon_on = 1'b1;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 1200 && done_cnt == 0; k++) step(1);
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_cycle"}, done_cyc, NWM * P + 1);
        chk({tag, "_mac_enable_count"}, mac_cnt, NWM * IFM_DEPTH);
        chk({tag, "_push_count"}, fifo_cnt, NWM);
        chk({tag, "_addr_trace_errors"}, addr_err, 0);
        chk({tag, "_wm_addr_span"}, exp_wm, NWM * IFM_DEPTH);
        chk({tag, "_enable_overlap"}, overlap_err, 0);
        chk({tag, "_scoreboard_left"}, exp_q.size(), 0);
        step(2);
        chk({tag, "_busy_after"}, bus.busy, 0);
        for (int k = 0; k < NWM; k++)
            chk({tag, "_fifo_out"}, fifo[k], weighted ? longint'(SUM1 * (k + 1)) : longint'(SUM1));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_fifo_enable"}, bus.fifo_enable, 0);
        chk({tag, "_mac_enable"}, bus.mac_enable, 0);
        chk({tag, "_mac_clear"}, bus.mac_clear, 0);
        chk({tag, "_ifm_addr"}, bus.ifm_addr, 0);
        chk({tag, "_wm_addr"}, bus.wm_addr, 0);
        chk({tag, "_neuron_idx"}, bus.neuron_idx, 0);
    endtask

    initial begin
        for (int k = 0; k < NWM; k++) fifo[k] = 0;
        clear_run();

        // Reset held with start asserted.
        bus.start = 1'b1;
        reset     = 1'b0;
        step(3);
        check_idle_outputs("reset");
        bus.start = 1'b0;
        reset     = 1'b1;
        step(2);
        chk("idle_after_reset_busy", bus.busy, 0);

        // Unit weights: every neuron sums to 3570.
        start_run(1'b0, 1'b0);
        wait_done();
        check_run("run_unit");

        // Neuron-scaled weights expose FIFO ordering.
        start_run(1'b1, 1'b0);
        wait_done();
        check_run("run_weighted");

        // Start held high through the run and the DONE cycle.
        start_run(1'b0, 1'b1);
        for (int k = 0; k < 1200 && (cyc - base) < NWM * P + 1; k++) step(1);
        bus.start = 1'b0;
        step(8);
        chk("held_done_count", done_cnt, 1);
        chk("held_done_cycle", done_cyc, NWM * P + 1);
        chk("held_mac_count", mac_cnt, NWM * IFM_DEPTH);
        chk("held_push_count", fifo_cnt, NWM);
        chk("held_no_restart_busy", bus.busy, 0);

        // Reset during neuron 3 accumulation.
        start_run(1'b0, 1'b0);
        for (int k = 0; k < 1200 && (cyc - base) < 300; k++) step(1);
        chk("midreset_neuron_before", bus.neuron_idx, 3);
        reset = 1'b0;
        step(1);
        check_idle_outputs("midreset");
        reset = 1'b1;
        step(900);
        chk("midreset_push_count", fifo_cnt, 3);
        chk("midreset_done_count", done_cnt, 0);
        chk("midreset_mac_count", mac_cnt, 4 * IFM_DEPTH - (4 * P - 300) + 2);

        // Fresh run after the aborted one.
        start_run(1'b1, 1'b0);
        wait_done();
        check_run("run_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
